// File: rtl/exp6_pkg.sv
// Shared state encodings (value doubles as the db_estado code) and default timing for the sequence presenter.
package exp6_pkg;

   typedef enum logic [3:0] {
      ST_OCIOSO  = 4'h0,
      ST_CARREGA = 4'h1,
      ST_ACENDE  = 4'h2,
      ST_APAGA   = 4'h3,
      ST_FINAL   = 4'hF
   } estado_t;

   localparam int unsigned T_ACESO_DEF   = 1000;
   localparam int unsigned T_APAGADO_DEF = 500;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/exp6_temporizador.sv
// Loadable down-counter: carrega loads valor, conta decrements until zero is reached.
module exp6_temporizador #(
   parameter int unsigned W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         carrega,
   input  logic         conta,
   input  logic [W-1:0] valor,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset)
         cnt <= '0;
      else if (carrega)
         cnt <= valor;
      else if (conta && (cnt != '0))
         cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/exp6_exibe_sequencia.sv
// Presents sequence memory entries 0..limite on the LEDs, each lit then dark, and pulses fim when done.
// Optional abort input is enabled by defining EXP6_EXIBE_ABORTA_EN.
module exp6_exibe_sequencia
   import exp6_pkg::*;
#(
   parameter int unsigned T_ACESO   = T_ACESO_DEF,
   parameter int unsigned T_APAGADO = T_APAGADO_DEF,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned DATA_W    = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic [ADDR_W-1:0] limite,
   input  logic [DATA_W-1:0] dado,
`ifdef EXP6_EXIBE_ABORTA_EN
   input  logic              abortar,
`endif
   output logic [ADDR_W-1:0] endereco,
   output logic [DATA_W-1:0] leds,
   output logic              ocupado,
   output logic              fim,
   output logic [3:0]        db_estado
);

   localparam int unsigned TMR_W = $clog2(max_u(T_ACESO, T_APAGADO) + 1);

   estado_t           state, state_n;
   logic [ADDR_W-1:0] lim_r, lim_n;
   logic [DATA_W-1:0] led_r, led_n;
   logic [ADDR_W-1:0] end_n;
   logic [DATA_W-1:0] leds_n;
   logic              ocupado_n, fim_n;
   logic              tmr_carrega, tmr_conta, tmr_zero;
   logic [TMR_W-1:0]  tmr_valor;
   logic              abort_req;

`ifdef EXP6_EXIBE_ABORTA_EN
   assign abort_req = abortar;
`else
   assign abort_req = 1'b0;
`endif

   exp6_temporizador #(.W(TMR_W)) u_tmr (
      .clock   (clock),
      .reset   (reset),
      .carrega (tmr_carrega),
      .conta   (tmr_conta),
      .valor   (tmr_valor),
      .zero    (tmr_zero)
   );

   // State and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_OCIOSO;
         lim_r    <= '0;
         led_r    <= '0;
         endereco <= '0;
         leds     <= '0;
         ocupado  <= 1'b0;
         fim      <= 1'b0;
      end else begin
         state    <= state_n;
         lim_r    <= lim_n;
         led_r    <= led_n;
         endereco <= end_n;
         leds     <= leds_n;
         ocupado  <= ocupado_n;
         fim      <= fim_n;
      end
   end

   // Next state, timer control and next output values
   always_comb begin
      state_n     = state;
      lim_n       = lim_r;
      led_n       = led_r;
      end_n       = endereco;
      tmr_carrega = 1'b0;
      tmr_conta   = 1'b0;
      tmr_valor   = '0;
      case (state)
         ST_OCIOSO: begin
            end_n = '0;
            if (iniciar) begin
               lim_n   = limite;
               state_n = ST_CARREGA;
            end
         end
         ST_CARREGA: begin
            led_n       = dado;
            tmr_carrega = 1'b1;
            tmr_valor   = TMR_W'(T_ACESO - 1);
            state_n     = ST_ACENDE;
         end
         ST_ACENDE: begin
            if (tmr_zero) begin
               tmr_carrega = 1'b1;
               tmr_valor   = TMR_W'(T_APAGADO - 1);
               state_n     = ST_APAGA;
            end else begin
               tmr_conta = 1'b1;
            end
         end
         ST_APAGA: begin
            if (tmr_zero) begin
               // compare before increment so endereco never wraps at the top entry
               if (endereco == lim_r) begin
                  state_n = ST_FINAL;
               end else begin
                  end_n   = endereco + ADDR_W'(1);
                  state_n = ST_CARREGA;
               end
            end else begin
               tmr_conta = 1'b1;
            end
         end
         ST_FINAL: begin
            end_n   = '0;
            state_n = ST_OCIOSO;
         end
         default: begin
            end_n   = '0;
            state_n = ST_OCIOSO;
         end
      endcase

      if (abort_req && (state inside {ST_CARREGA, ST_ACENDE, ST_APAGA})) begin
         end_n   = '0;
         state_n = ST_FINAL;
      end

      leds_n    = (state_n == ST_ACENDE) ? led_n : '0;
      ocupado_n = (state_n inside {ST_CARREGA, ST_ACENDE, ST_APAGA});
      fim_n     = (state_n == ST_FINAL);
   end

   assign db_estado = state;

endmodule

// File: tb/tb_exp6_exibe_sequencia.sv
// Directed bench for exp6_exibe_sequencia with T_ACESO=4, T_APAGADO=2; define EXP6_EXIBE_ABORTA_EN for the abort case.
module tb_exp6_exibe_sequencia;

   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned DATA_W    = 4;
   localparam int unsigned T_ACESO   = 4;
   localparam int unsigned T_APAGADO = 2;
   localparam int          PER       = 1 + T_ACESO + T_APAGADO;

   logic              clock = 1'b0;
   logic              reset;
   logic              iniciar;
   logic [ADDR_W-1:0] limite;
   logic [DATA_W-1:0] dado;
   logic [ADDR_W-1:0] endereco;
   logic [DATA_W-1:0] leds;
   logic              ocupado;
   logic              fim;
   logic [3:0]        db_estado;
`ifdef EXP6_EXIBE_ABORTA_EN
   logic              abortar;
`endif

   logic [DATA_W-1:0] mem [16];
   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   assign dado = mem[endereco];

   exp6_exibe_sequencia #(
      .T_ACESO   (T_ACESO),
      .T_APAGADO (T_APAGADO),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .iniciar   (iniciar),
      .limite    (limite),
      .dado      (dado),
`ifdef EXP6_EXIBE_ABORTA_EN
      .abortar   (abortar),
`endif
      .endereco  (endereco),
      .leds      (leds),
      .ocupado   (ocupado),
      .fim       (fim),
      .db_estado (db_estado)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_all(input string tag, input int t, input int e_db, input int e_leds,
                            input int e_ocup, input int e_fim);
      check($sformatf("%s t=%0d db_estado", tag, t), 32'(db_estado), 32'(e_db));
      check($sformatf("%s t=%0d leds", tag, t),      32'(leds),      32'(e_leds));
      check($sformatf("%s t=%0d ocupado", tag, t),   32'(ocupado),   32'(e_ocup));
      check($sformatf("%s t=%0d fim", tag, t),       32'(fim),       32'(e_fim));
   endtask

   // t counts cycles after the edge that sampled iniciar; expectations follow the per-entry period of 7 cycles
   task automatic run_seq(input string tag, input int lim, input int poke_t, input int stop_t);
      int tfin, e, p;
      tfin = 1 + (lim + 1) * PER;
      @(negedge clock);
      iniciar = 1'b1;
      limite  = 4'(lim);
      step();
      iniciar = 1'b0;
      for (int t = 1; t <= tfin + 1; t++) begin
         if (t < tfin) begin
            e = (t - 1) / PER;
            p = (t - 1) % PER;
            check_all(tag, t, (p == 0) ? 1 : (p <= T_ACESO) ? 2 : 3,
                      (p >= 1 && p <= T_ACESO) ? int'(mem[e]) : 0, 1, 0);
            check($sformatf("%s t=%0d endereco", tag, t), 32'(endereco), 32'(e));
         end else if (t == tfin) begin
            check_all(tag, t, 15, 0, 0, 1);
         end else begin
            check_all(tag, t, 0, 0, 0, 0);
            check($sformatf("%s t=%0d endereco", tag, t), 32'(endereco), 32'd0);
         end
         if (t == stop_t) return;
         if (t == poke_t) begin
            iniciar = 1'b1;
            limite  = 4'd5;
         end
         if (t <= tfin) step();
         if (t == poke_t) begin
            iniciar = 1'b0;
            limite  = 4'(lim);
         end
      end
   endtask

   initial begin
      mem = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'h6, 4'h9,
              4'hA, 4'hC, 4'h7, 4'hB, 4'hD, 4'hE, 4'hF, 4'h0};
      reset   = 1'b1;
      iniciar = 1'b0;
      limite  = '0;
`ifdef EXP6_EXIBE_ABORTA_EN
      abortar = 1'b0;
`endif
      step();
      step();
      check_all("reset", 0, 0, 0, 0, 0);
      check("reset endereco", 32'(endereco), 32'd0);
      reset = 1'b0;
      step();

      // three entries, full per-cycle timeline
      run_seq("lim2", 2, -1, -1);
      // single entry; iniciar pulsed while in final is ignored
      run_seq("lim0", 0, 8, -1);
      // every entry, including the last (dado=0), no address wrap
      run_seq("lim15", 15, -1, -1);
      // iniciar and limite change during acende of entry 0 are ignored
      run_seq("busy", 2, 3, -1);

      // reset during second entry's acende
      run_seq("rst", 2, -1, 10);
      reset = 1'b1;
      step();
      check_all("rst_hit", 0, 0, 0, 0, 0);
      check("rst_hit endereco", 32'(endereco), 32'd0);
      reset = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         check_all("rst_after", i, 0, 0, 0, 0);
      end
      run_seq("restart", 1, -1, -1);

`ifdef EXP6_EXIBE_ABORTA_EN
      // abort during apaga of entry 1
      run_seq("abort", 3, -1, 13);
      abortar = 1'b1;
      step();
      abortar = 1'b0;
      check_all("abort_hit", 0, 15, 0, 0, 1);
      check("abort_hit endereco", 32'(endereco), 32'd0);
      step();
      check_all("abort_after", 1, 0, 0, 0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
